// File: rtl/timer_pkg.sv
// Shared types and default constants for the multi-channel millisecond timer.
package timer_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    localparam int unsigned DefNumCh     = 4;
    localparam int unsigned DefIntW      = 16;
    localparam int unsigned DefCntW      = 32;
    localparam int unsigned DefTickShift = 13;
    localparam int unsigned TicksPerMs   = 1 << DefTickShift;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, run state, reload mode and sticky expired flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned INT_W      = DefIntW,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned TICK_SHIFT = DefTickShift
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_gwe,
    input  logic             i_wr,
    input  logic [INT_W-1:0] i_interval,
    input  logic             i_periodic,
    input  logic             i_stop,
    input  logic             i_rd,
    output logic             o_flag
);

    ch_state_e        r_state, w_state_d;
    logic             r_periodic, w_periodic_d;
    logic [INT_W-1:0] r_interval, w_interval_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_flag, w_flag_d;

    logic [CNT_W-1:0] w_load_new;
    logic [CNT_W-1:0] w_load_old;
    logic             w_stop_eff;
    logic             w_expire;

    assign w_load_new = CNT_W'(i_interval) << TICK_SHIFT;
    assign w_load_old = CNT_W'(r_interval) << TICK_SHIFT;

    // A load on the same edge overrides a stop; an effective stop suppresses expiry.
    assign w_stop_eff = i_stop & ~i_wr;
    assign w_expire   = (r_state == StRun) && (r_cnt == '0) && !w_stop_eff;

    always_comb begin
        w_state_d    = r_state;
        w_periodic_d = r_periodic;
        w_interval_d = r_interval;
        w_cnt_d      = r_cnt;
        w_flag_d     = r_flag;

        if (i_wr) begin
            w_cnt_d      = w_load_new;
            w_interval_d = i_interval;
            w_periodic_d = i_periodic;
            w_state_d    = StRun;
        end else if (i_stop) begin
            w_state_d = StIdle;
        end else if (r_state == StRun) begin
            if (r_cnt != '0) begin
                w_cnt_d = r_cnt - CNT_W'(1);
            end else if (r_periodic) begin
                w_cnt_d = w_load_old;
            end else begin
                w_state_d = StIdle;
            end
        end

        if (w_expire) begin
            w_flag_d = 1'b1;
        end else if (i_rd) begin
            w_flag_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_periodic <= 1'b0;
            r_interval <= '0;
            r_cnt      <= '0;
            r_flag     <= 1'b0;
        end else if (i_gwe) begin
            r_state    <= w_state_d;
            r_periodic <= w_periodic_d;
            r_interval <= w_interval_d;
            r_cnt      <= w_cnt_d;
            r_flag     <= w_flag_d;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent ms timers with read-to-clear expiry flags.
// Define MULTI_TIMER_IRQ_EN to add the interrupt mask register and registered irq.
module multi_timer
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH     = DefNumCh,
    parameter int unsigned INT_W      = DefIntW,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned TICK_SHIFT = DefTickShift,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              GWE,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [INT_W-1:0]  wr_interval,
    input  logic              wr_periodic,
    input  logic              stop_en,
    input  logic [CH_W-1:0]   stop_ch,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              status_out,
    output logic [NUM_CH-1:0] status_vec,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_in,
    output logic              irq
);

    if (INT_W + TICK_SHIFT > CNT_W) begin : g_width_err
        $error("multi_timer: INT_W + TICK_SHIFT must not exceed CNT_W");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_num_ch_err
        $error("multi_timer: NUM_CH must be in 1..16");
    end

    logic [NUM_CH-1:0] w_flags;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr, w_stop, w_rd;

        assign w_wr   = wr_en   && (wr_ch   == CH_W'(i));
        assign w_stop = stop_en && (stop_ch == CH_W'(i));
        assign w_rd   = rd_en   && (rd_ch   == CH_W'(i));

        timer_channel #(
            .INT_W      (INT_W),
            .CNT_W      (CNT_W),
            .TICK_SHIFT (TICK_SHIFT)
        ) u_ch (
            .i_clk      (CLK),
            .i_rst_n    (RST),
            .i_gwe      (GWE),
            .i_wr       (w_wr),
            .i_interval (wr_interval),
            .i_periodic (wr_periodic),
            .i_stop     (w_stop),
            .i_rd       (w_rd),
            .o_flag     (w_flags[i])
        );
    end

    assign status_vec = w_flags;
    // Shows the flag before any clear taking effect at the coming edge.
    assign status_out = w_flags[rd_ch];

`ifdef MULTI_TIMER_IRQ_EN
    logic [NUM_CH-1:0] r_mask;
    logic              r_irq;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else if (GWE) begin
            if (mask_we) begin
                r_mask <= mask_in;
            end
            r_irq <= |(w_flags & r_mask);
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_mask;

    assign w_unused_mask = ^{mask_we, mask_in};
    assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Randomized and directed bench for multi_timer with a deadline-based reference model.
module tb_multi_timer;

    localparam int unsigned NCH = 4;
    localparam int unsigned TS  = 2;
`ifdef MULTI_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           CLK;
    logic           RST;
    logic           GWE;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [7:0]     wr_interval;
    logic           wr_periodic;
    logic           stop_en;
    logic [1:0]     stop_ch;
    logic           rd_en;
    logic [1:0]     rd_ch;
    logic           status_out;
    logic [NCH-1:0] status_vec;
    logic           mask_we;
    logic [NCH-1:0] mask_in;
    logic           irq;

    multi_timer #(
        .NUM_CH     (NCH),
        .INT_W      (8),
        .CNT_W      (16),
        .TICK_SHIFT (TS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .GWE         (GWE),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_interval (wr_interval),
        .wr_periodic (wr_periodic),
        .stop_en     (stop_en),
        .stop_ch     (stop_ch),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .status_out  (status_out),
        .status_vec  (status_vec),
        .mask_we     (mask_we),
        .mask_in     (mask_in),
        .irq         (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NCH-1:0] vec;
        logic           so;
        logic           irq;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: each running channel keeps the GWE-edge index at which it expires next.
    int unsigned    m_g = 0;
    bit             m_run[NCH];
    bit             m_per[NCH];
    int unsigned    m_len[NCH];
    int unsigned    m_due[NCH];
    bit [NCH-1:0]   m_flag = '0;
    bit [NCH-1:0]   m_mask = '0;
    bit             m_irq  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [NCH-1:0] f_old;
        bit [NCH-1:0] mk_old;
        f_old  = m_flag;
        mk_old = m_mask;
        if (!RST) begin
            for (int c = 0; c < NCH; c++) m_run[c] = 1'b0;
            m_flag = '0;
            m_mask = '0;
            m_irq  = 1'b0;
            return;
        end
        if (!GWE) return;
        m_g++;
        for (int c = 0; c < NCH; c++) begin
            bit w, s, r, ex;
            w  = wr_en   && (wr_ch   == c);
            s  = stop_en && (stop_ch == c);
            r  = rd_en   && (rd_ch   == c);
            ex = m_run[c] && (m_due[c] == m_g) && !(s && !w);
            if (w) begin
                m_run[c] = 1'b1;
                m_per[c] = wr_periodic;
                m_len[c] = wr_interval * (1 << TS);
                m_due[c] = m_g + m_len[c] + 1;
            end else if (s) begin
                m_run[c] = 1'b0;
            end else if (ex) begin
                if (m_per[c]) m_due[c] = m_due[c] + m_len[c] + 1;
                else          m_run[c] = 1'b0;
            end
            if (ex)     m_flag[c] = 1'b1;
            else if (r) m_flag[c] = 1'b0;
        end
        if (IRQ_ON && mask_we) m_mask = mask_in;
        m_irq = IRQ_ON ? |(f_old & mk_old) : 1'b0;
    endtask

    // Push the expectation for the coming negedge, advance the model, then cross the edge.
    task automatic cycle();
        exp_t e;
        e.vec = m_flag;
        e.so  = m_flag[rd_ch];
        e.irq = m_irq;
        sb_q.push_back(e);
        model_edge();
        @(posedge CLK);
        #2;
        wr_en   = 1'b0;
        stop_en = 1'b0;
        rd_en   = 1'b0;
        mask_we = 1'b0;
    endtask

    task automatic load(input int ch, input int iv, input bit per);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_interval = 8'(iv); wr_periodic = per;
        cycle();
    endtask

    task automatic read_clear(input int ch);
        rd_en = 1'b1; rd_ch = 2'(ch);
        cycle();
    endtask

    task automatic wait_rise(input int ch, input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!status_vec[ch] && n < limit);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (status_vec !== mon_e.vec) begin
                n_fail++;
                $display("FAIL status_vec: got %b expected %b (t=%0t)", status_vec, mon_e.vec, $time);
            end
            n_tests++;
            if (status_out !== mon_e.so) begin
                n_fail++;
                $display("FAIL status_out: got %b expected %b (t=%0t)", status_out, mon_e.so, $time);
            end
            n_tests++;
            if (irq !== mon_e.irq) begin
                n_fail++;
                $display("FAIL irq: got %b expected %b (t=%0t)", irq, mon_e.irq, $time);
            end
        end
    end

    initial begin
        int n;
        RST = 1'b0; GWE = 1'b1;
        wr_en = 1'b0; wr_ch = '0; wr_interval = '0; wr_periodic = 1'b0;
        stop_en = 1'b0; stop_ch = '0; rd_en = 1'b0; rd_ch = '0;
        mask_we = 1'b0; mask_in = '0;
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 1'b0; m_per[c] = 1'b0; m_len[c] = 0; m_due[c] = 0;
        end
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        repeat (2) cycle();

        // One-shot ch0, interval 3
        load(0, 3, 1'b0);
        wait_rise(0, 40, n);
        check("oneshot_rise_edges", n, 13);
        read_clear(0);
        repeat (20) cycle();
        check("oneshot_stays_idle", int'(status_vec[0]), 0);

        // Periodic ch1, interval 1
        load(1, 1, 1'b1);
        wait_rise(1, 40, n);
        check("periodic_first_rise", n, 5);
        rd_en = 1'b1; rd_ch = 2'd1;
        #1;
        check("status_out_preclear", int'(status_out), 1);
        cycle();
        check("periodic_cleared", int'(status_vec[1]), 0);
        wait_rise(1, 40, n);
        check("periodic_second_rise", n, 4);
        read_clear(1);
        repeat (3) cycle();
        read_clear(1);
        check("read_at_expiry_keeps_flag", int'(status_vec[1]), 1);
        stop_en = 1'b1; stop_ch = 2'd1;
        cycle();
        read_clear(1);
        repeat (12) cycle();
        check("periodic_stopped", int'(status_vec[1]), 0);

        // GWE freeze on ch2
        load(2, 2, 1'b0);
        repeat (3) cycle();
        GWE = 1'b0;
        repeat (7) cycle();
        GWE = 1'b1;
        wait_rise(2, 40, n);
        check("gwe_freeze_remaining", n, 6);
        read_clear(2);

        // Reset mid-count on ch3 (counter at 5)
        load(3, 2, 1'b0);
        repeat (3) cycle();
        RST = 1'b0;
        cycle();
        RST = 1'b1;
        check("reset_status_vec", int'(status_vec), 0);
        check("reset_status_out", int'(status_out), 0);
        check("reset_irq", int'(irq), 0);
        repeat (15) cycle();
        check("reset_no_expiry", int'(status_vec), 0);

        // Reload ch0 while running
        load(0, 5, 1'b0);
        repeat (6) cycle();
        load(0, 2, 1'b0);
        wait_rise(0, 40, n);
        check("reload_rise_edges", n, 9);
        read_clear(0);

        // Interrupt masking: only ch1 enabled
        mask_we = 1'b1; mask_in = 4'b0010;
        cycle();
        load(0, 1, 1'b0);
        load(1, 2, 1'b0);
        wait_rise(1, 40, n);
        check("irq_ch1_rise", n, 9);
        check("irq_ch0_flag", int'(status_vec[0]), 1);
        check("irq_lags_flag", int'(irq), 0);
        cycle();
        check("irq_set", int'(irq), int'(IRQ_ON));
        read_clear(1);
        check("irq_held_at_read", int'(irq), int'(IRQ_ON));
        cycle();
        check("irq_dropped", int'(irq), 0);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            GWE         = ($urandom_range(0, 9) != 0);
            RST         = ($urandom_range(0, 299) != 0);
            wr_en       = ($urandom_range(0, 5) == 0);
            wr_ch       = 2'($urandom_range(0, 3));
            wr_interval = 8'($urandom_range(0, 4));
            wr_periodic = 1'($urandom_range(0, 1));
            stop_en     = ($urandom_range(0, 11) == 0);
            stop_ch     = 2'($urandom_range(0, 3));
            rd_en       = ($urandom_range(0, 3) == 0);
            rd_ch       = 2'($urandom_range(0, 3));
            mask_we     = ($urandom_range(0, 19) == 0);
            mask_in     = 4'($urandom_range(0, 15));
            cycle();
        end
        RST = 1'b1;
        GWE = 1'b1;

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
